// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: TX state encoding, register map
// and parity mode codes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // mem_addr[2] selects between the data/status word and the control word
    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Bus-attached UART transmitter: register decode, control word, TX FIFO,
// baud counter and frame serialiser with optional parity and two stop bits.
module uart_tx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 867
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    output logic        serial_out,
    output logic        irq
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(FIFO_DEPTH / 2);

    function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? DIV_WIDTH'(1) : d;
    endfunction

    logic                 rdy_q, ovf_q, ovf_d;
    logic [31:0]          rdata_q, ctrl_word, status_word;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [15:0]          div16;
    logic [1:0]           par_q, par_d;
    logic                 stop2_q, stop2_d, irq_en_q, irq_en_d;
    logic                 accept, sel_ctrl, push, load, rd_status, idle;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full, fifo_empty;

    tx_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] baud_q, baud_d, fdiv_q, fdiv_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           fpar_q, fpar_d;
    logic                 fstop2_q, fstop2_d, acc_q, acc_d, stop_q, stop_d, tx_q, tx_d, tick;
    logic                 unused_bits;

    assign unused_bits = ^{mem_instr, mem_addr[31:3], mem_addr[1:0], mem_wdata[31:20], mem_wstrb[3]};

    // Side effects happen only on the accept cycle; the reply follows one cycle later
    assign accept    = mem_valid && enable && !rdy_q;
    assign sel_ctrl  = (mem_addr[2] == REG_CTRL);
    assign push      = accept && (mem_addr[2] == REG_DATA) && mem_wstrb[0];
    assign rd_status = accept && (mem_addr[2] == REG_DATA) && (mem_wstrb == 4'b0000);

    assign idle        = (state_q == ST_IDLE) && fifo_empty;
    assign ctrl_word   = {12'b0, irq_en_q, stop2_q, par_q, 16'(div_q)};
    assign status_word = {16'(fifo_count), 12'b0, ovf_q, idle, fifo_empty, !fifo_full};
    assign mem_ready   = enable && rdy_q;
    assign mem_rdata   = mem_ready ? rdata_q : 32'b0;
    assign irq         = irq_en_q && (fifo_count <= HALF_CNT);
    assign serial_out  = tx_q;

    always_comb begin
        div16    = 16'(div_q);
        par_d    = par_q;
        stop2_d  = stop2_q;
        irq_en_d = irq_en_q;
        if (accept && sel_ctrl) begin
            if (mem_wstrb[0]) div16[7:0]  = mem_wdata[7:0];
            if (mem_wstrb[1]) div16[15:8] = mem_wdata[15:8];
            if (mem_wstrb[2]) begin
                par_d    = mem_wdata[17:16];
                stop2_d  = mem_wdata[18];
                irq_en_d = mem_wdata[19];
            end
        end
        div_d = DIV_WIDTH'(div16);
        // A drop in the same cycle as the clearing read must still be reported
        ovf_d = ovf_q;
        if (rd_status) ovf_d = 1'b0;
        if (push && fifo_full && !load) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_q    <= 1'b0;
            div_q    <= DIV_WIDTH'(DEFAULT_DIV);
            par_q    <= PAR_NONE;
            stop2_q  <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rdy_q    <= accept;
            div_q    <= div_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) rdata_q <= sel_ctrl ? ctrl_word : status_word;
    end

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (mem_wdata[DATA_BITS-1:0]),
        .pop    (load),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        stop_d   = stop_q;
        tx_d     = tx_q;
        fdiv_d   = fdiv_q;
        fpar_d   = fpar_q;
        fstop2_d = fstop2_q;
        load     = 1'b0;
        tick     = (baud_q == '0);
        if (state_q != ST_IDLE) baud_d = tick ? fdiv_q : baud_q - 1'b1;
        unique case (state_q)
            ST_IDLE:  load = !fifo_empty;
            ST_START: if (tick) begin
                state_d = ST_DATA;
                tx_d    = shift_q[0];
            end
            ST_DATA: if (tick) begin
                acc_d   = acc_q ^ shift_q[0];
                shift_d = shift_q >> 1;
                if (bit_q == LAST_BIT) begin
                    if (parity_enabled(fpar_q)) begin
                        state_d = ST_PARITY;
                        tx_d    = acc_q ^ shift_q[0] ^ (fpar_q == PAR_ODD);
                    end else begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                    tx_d  = shift_q[1];
                end
            end
            ST_PARITY: if (tick) begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
            end
            ST_STOP: if (tick) begin
                if (fstop2_q && !stop_q) stop_d = 1'b1;
                else if (!fifo_empty)    load   = 1'b1;
                else begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Frame settings are frozen here so CTRL writes only affect the next frame
        if (load) begin
            state_d  = ST_START;
            tx_d     = 1'b0;
            fdiv_d   = eff_div(div_q);
            baud_d   = eff_div(div_q);
            fpar_d   = par_q;
            fstop2_d = stop2_q;
            shift_d  = fifo_dout;
            acc_d    = 1'b0;
            bit_d    = '0;
            stop_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            acc_q    <= 1'b0;
            stop_q   <= 1'b0;
            tx_q     <= 1'b1;
            fdiv_q   <= DIV_WIDTH'(1);
            fpar_q   <= PAR_NONE;
            fstop2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            acc_q    <= acc_d;
            stop_q   <= stop_d;
            tx_q     <= tx_d;
            fdiv_q   <= fdiv_d;
            fpar_q   <= fpar_d;
            fstop2_q <= fstop2_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule
